sa_cache: RTL

- Parametrised, blocking, write-back / write-allocate set-associative data cache.
- Sits between the core load/store unit and the memory bus.
- Generalises the existing fixed 64-set, 16-byte-line cache: configurable sets, ways and line size; tree-PLRU victim selection; valid/ready handshakes on both sides; alignment error reporting.
- One outstanding CPU request at a time.

---
 rtl/sa_cache_pkg.sv | 30 +++
 rtl/sa_cache_plru.sv | 61 ++++++
 rtl/sa_cache.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sa_cache_pkg.sv
// Shared encodings and address-split width helpers for the set-associative data cache.
// No logic; sizes everything derived from ADDR_W / LINE_BYTES / SETS.
package cache_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        RESP      = 3'd4
    } state_e;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    // SETS must be at least 2 so the index field is never empty.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
        return addr_w - off_w(line_bytes) - idx_w(sets);
    endfunction

endpackage

// File: rtl/sa_cache_plru.sv
// Per-set tree pseudo-LRU: combinational victim for the indexed set, one-cycle touch update.
// No handshake; touch_en_i is a single-cycle strobe from the cache controller.
module sa_cache_plru
    import cache_pkg::*;
#(
    parameter  int SETS  = 64,
    parameter  int WAYS  = 4,
    localparam int IDX_W = idx_w(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             touch_en_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAY_W-1:0] victim_o
);

    if (WAYS == 1) begin : g_direct
        assign victim_o = '0;
    end else begin : g_tree
        localparam int LVL = $clog2(WAYS);

        // Heap-numbered tree: node n lives at bit n, children 2n / 2n+1; bit 0 is spare.
        logic [WAYS-1:0] bits_q [SETS];
        logic [WAYS-1:0] cur;
        logic [WAYS-1:0] bits_d;

        assign cur = bits_q[idx_i];

        always_comb begin : touch_path
            int node;
            bits_d = cur;
            node   = 1;
            for (int l = 0; l < LVL; l++) begin
                bits_d[node] = ~touch_way_i[LVL-1-l];
                node         = 2 * node + (touch_way_i[LVL-1-l] ? 1 : 0);
            end
        end

        always_comb begin : victim_walk
            int node;
            node = 1;
            for (int l = 0; l < LVL; l++) begin
                node = 2 * node + (cur[node] ? 1 : 0);
            end
            victim_o = WAY_W'(node - WAYS);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < SETS; s++) begin
                    bits_q[s] <= '0;
                end
            end else if (touch_en_i) begin
                bits_q[idx_i] <= bits_d;
            end
        end
    end

endmodule

// File: rtl/sa_cache.sv
// Blocking write-back/write-allocate set-associative cache; hit answers 1 cycle after accept.
// One request in flight: cpu_req_ready only in IDLE; memory side waits on wr/rd ready and fill valid.
module sa_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_we,
    input  logic [ADDR_W-1:0]       cpu_req_addr,
    input  logic [DATA_W-1:0]       cpu_req_wdata,
    input  logic [1:0]              cpu_req_size,
    output logic                    cpu_resp_valid,
    output logic [DATA_W-1:0]       cpu_resp_rdata,
    output logic                    cpu_resp_err,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [ADDR_W-1:0]       mem_wr_addr,
    output logic [LINE_BYTES*8-1:0] mem_wr_data,
    output logic                    mem_rd_valid,
    input  logic                    mem_rd_ready,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic                    mem_rd_data_valid,
    input  logic [LINE_BYTES*8-1:0] mem_rd_data
);

    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, SETS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = LINE_BYTES * 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [1:0]          size_q;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic                rd_acc_q, rd_acc_d;

    logic [LINE_W-1:0]   data_q  [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [OFF_W-1:0]    off;
    logic [OFF_W+2:0]    bitpos;
    logic                hit, free, req_err;
    logic [WAY_W-1:0]    hit_way, free_way, plru_victim, acc_way;
    logic                do_access, do_fill, do_wb;
    logic [LINE_W-1:0]   line, wr_mask, wr_line;
    logic [DATA_W-1:0]   size_mask, load_data;

    assign idx    = addr_q[OFF_W +: IDX_W];
    assign tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign off    = addr_q[OFF_W-1:0];
    assign bitpos = {off, 3'b000};

    assign req_err = (size_q == 2'd3)
                  || (size_q == SZ_HALF && addr_q[0])
                  || (size_q == SZ_WORD && addr_q[1:0] != 2'b00);

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: size_mask = DATA_W'(32'h0000_00FF);
            SZ_HALF: size_mask = DATA_W'(32'h0000_FFFF);
            default: size_mask = '1;
        endcase
    end

    // Hits and the post-fill access share one datapath; RESP always targets the filled way.
    assign acc_way   = (state_q == RESP) ? victim_q : hit_way;
    assign line      = data_q[idx][acc_way];
    assign load_data = DATA_W'(line >> bitpos) & size_mask;
    assign wr_mask   = LINE_W'(size_mask) << bitpos;
    assign wr_line   = (line & ~wr_mask) | (LINE_W'(wdata_q & size_mask) << bitpos);

    sa_cache_plru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_plru (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (idx),
        .touch_en_i  (do_access),
        .touch_way_i (acc_way),
        .victim_o    (plru_victim)
    );

    always_comb begin
        state_d        = state_q;
        victim_d       = victim_q;
        rd_acc_d       = rd_acc_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_err   = 1'b0;
        mem_wr_valid   = 1'b0;
        mem_rd_valid   = 1'b0;
        do_access      = 1'b0;
        do_fill        = 1'b0;
        do_wb          = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (req_err) begin
                    cpu_resp_valid = 1'b1;
                    cpu_resp_err   = 1'b1;
                    state_d        = IDLE;
                end else if (hit) begin
                    cpu_resp_valid = 1'b1;
                    do_access      = 1'b1;
                    state_d        = IDLE;
                end else begin
                    victim_d = free ? free_way : plru_victim;
                    state_d  = (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready) begin
                    do_wb   = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (!rd_acc_q) begin
                    mem_rd_valid = 1'b1;
                    if (mem_rd_ready) rd_acc_d = 1'b1;
                end else if (mem_rd_data_valid) begin
                    do_fill  = 1'b1;
                    rd_acc_d = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                do_access      = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_resp_rdata = (do_access && !we_q) ? load_data : '0;
    assign mem_wr_addr    = mem_wr_valid ? {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}} : '0;
    assign mem_wr_data    = mem_wr_valid ? data_q[idx][victim_q] : '0;
    assign mem_rd_addr    = mem_rd_valid ? {tag, idx, {OFF_W{1'b0}}} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            size_q   <= SZ_WORD;
            victim_q <= '0;
            rd_acc_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            rd_acc_q <= rd_acc_d;
            if (cpu_req_valid && cpu_req_ready) begin
                addr_q  <= cpu_req_addr;
                we_q    <= cpu_req_we;
                wdata_q <= cpu_req_wdata;
                size_q  <= cpu_req_size;
            end
            if (do_wb) dirty_q[idx][victim_q] <= 1'b0;
            if (do_fill) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
            if (do_access && we_q) dirty_q[idx][acc_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_fill) begin
            data_q[idx][victim_q] <= mem_rd_data;
            tag_q[idx][victim_q]  <= tag;
        end
        if (do_access && we_q) data_q[idx][acc_way] <= wr_line;
    end

endmodule
